// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
// Eight-digit time-multiplexed seven-segment driver. The 500 Hz scan clock is
// treated as data: its rising edge (seen in the clk_100M domain) advances the
// scan by one digit. A staged value is swapped into the displayed value only
// when the scan wraps from digit 7 to digit 0, so each frame is consistent.
//
// Ports:
//   clk_100M    system clock, all registers on its rising edge
//   rst         synchronous active-high reset
//   clk_500     500 Hz scan square wave (already registered in clk_100M)
//   data_in     32-bit value, digit i = data_in[4i+3:4i], digit 0 rightmost
//   dp_in       per-digit decimal point, bit i belongs to digit i
//   load        single-cycle strobe staging data_in/dp_in
//   blank_lz    leading-zero suppression enable (live level)
//   an          one-hot digit enables
//   seg         segments {g,f,e,d,c,b,a}
//   dp          decimal point segment
//   frame_done  one-cycle pulse after a frame-boundary swap
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic        clk_100M,
    input  logic        rst,
    input  logic        clk_500,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        load,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_done
);

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned IDX_W      = 3;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;

    // Glyphs are held in active-low form internally; this is "all off".
    localparam logic [SEG_W-1:0]      GLYPH_BLANK = 7'h7F;
    localparam logic [NUM_DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [SEG_W-1:0]      SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Displayed / staged payload: decimal points plus hex data.
    typedef struct packed {
        logic [NUM_DIGITS-1:0] dp;
        logic [DATA_W-1:0]     data;
    } frame_t;

    // Active-low hex glyph, lowercase b and d.
    function automatic logic [SEG_W-1:0] hex_glyph(input logic [NIB_W-1:0] nib);
        logic [SEG_W-1:0] g;
        case (nib)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // State registers
    logic             clk_500_q;
    logic [IDX_W-1:0] idx;
    frame_t           shown;
    frame_t           pending;
    logic             pend_valid;

    // Next-state values
    logic             clk_500_q_nxt;
    logic [IDX_W-1:0] idx_nxt;
    frame_t           shown_nxt;
    frame_t           pending_nxt;
    logic             pend_valid_nxt;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [SEG_W-1:0]      seg_nxt;
    logic                  dp_nxt;
    logic                  frame_done_nxt;

    // Combinational helpers
    logic                  tick_c;
    logic                  wrap_c;
    logic                  zero_above_c;
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic [NIB_W-1:0]      nib_c;
    logic [SEG_W-1:0]      glyph_c;
    logic [NUM_DIGITS-1:0] onehot_c;

    // Register stage
    always_ff @(posedge clk_100M) begin
        if (rst) begin
            clk_500_q  <= 1'b0;
            idx        <= IDX_LAST;
            shown      <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            an         <= AN_OFF;
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            frame_done <= 1'b0;
        end else begin
            clk_500_q  <= clk_500_q_nxt;
            idx        <= idx_nxt;
            shown      <= shown_nxt;
            pending    <= pending_nxt;
            pend_valid <= pend_valid_nxt;
            an         <= an_nxt;
            seg        <= seg_nxt;
            dp         <= dp_nxt;
            frame_done <= frame_done_nxt;
        end
    end

    // Scan advance, frame-boundary swap and staging
    always_comb begin
        clk_500_q_nxt  = clk_500;
        idx_nxt        = idx;
        shown_nxt      = shown;
        pending_nxt    = pending;
        pend_valid_nxt = pend_valid;
        frame_done_nxt = 1'b0;

        tick_c = clk_500 & ~clk_500_q;
        wrap_c = tick_c & (idx == IDX_LAST);

        if (tick_c) begin
            idx_nxt = idx + IDX_W'(1);
        end

        // Swap consumes the pending value held before this edge.
        if (wrap_c && pend_valid) begin
            shown_nxt      = pending;
            pend_valid_nxt = 1'b0;
            frame_done_nxt = 1'b1;
        end

        // A load in the wrap cycle re-arms the stage (set wins over clear).
        if (load) begin
            pending_nxt.data = data_in;
            pending_nxt.dp   = dp_in;
            pend_valid_nxt   = 1'b1;
        end
    end

    // Output encode from the next-state digit and frame; held between ticks
    always_comb begin
        an_nxt  = an;
        seg_nxt = seg;
        dp_nxt  = dp;

        // Digit i is a leading zero when nibbles 7..i are all zero; digit 0 never is.
        zero_above_c = 1'b1;
        lz_blank_c   = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            zero_above_c  = zero_above_c & (shown_nxt.data[i*NIB_W +: NIB_W] == NIB_W'(0));
            lz_blank_c[i] = zero_above_c;
        end

        nib_c    = shown_nxt.data[{idx_nxt, 2'b00} +: NIB_W];
        glyph_c  = (blank_lz && lz_blank_c[idx_nxt]) ? GLYPH_BLANK : hex_glyph(nib_c);
        onehot_c = NUM_DIGITS'(1) << idx_nxt;

        if (tick_c) begin
            an_nxt  = AN_ACTIVE_LOW ? ~onehot_c : onehot_c;
            seg_nxt = SEG_ACTIVE_LOW ? glyph_c : ~glyph_c;
            // Blanked digits still carry their decimal point.
            dp_nxt  = SEG_ACTIVE_LOW ? ~shown_nxt.dp[idx_nxt] : shown_nxt.dp[idx_nxt];
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
// Directed scenarios followed by randomized traffic, checked every cycle
// against a frame-level reference model plus literal glyph checks.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    logic        clk_100M;
    logic        rst;
    logic        clk_500;
    logic [31:0] data_in;
    logic [7:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;
    logic        frame_done;

    int total = 0;
    int bad   = 0;

    seg7_scan_ctrl dut (
        .clk_100M   (clk_100M),
        .rst        (rst),
        .clk_500    (clk_500),
        .data_in    (data_in),
        .dp_in      (dp_in),
        .load       (load),
        .blank_lz   (blank_lz),
        .an         (an),
        .seg        (seg),
        .dp         (dp),
        .frame_done (frame_done)
    );

    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    // Active-low hex glyphs
    logic [6:0] glyph [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference model: displayed frame, staged frame, scan position
    int          m_idx;
    logic [31:0] m_data;
    logic [7:0]  m_dpb;
    logic [31:0] p_data;
    logic [7:0]  p_dpb;
    bit          m_pv;
    bit          m_prev;
    logic [7:0]  exp_an;
    logic [6:0]  exp_seg;
    logic        exp_dp;
    logic        exp_fd;

    // Leading zeros: everything from digit i upward is zero.
    function automatic logic [6:0] ref_seg(logic [31:0] d, int i, bit bl);
        logic [31:0] upper;
        upper = d >> (4 * i);
        if (bl && i > 0 && upper == 32'd0) return 7'h7F;
        return glyph[int'(upper & 32'hF)];
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic step();
        bit tick;
        @(posedge clk_100M);
        if (rst) begin
            m_idx = 7; m_data = '0; m_dpb = '0; p_data = '0; p_dpb = '0;
            m_pv = 0; m_prev = 0;
            exp_an = 8'hFF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fd = 1'b0;
        end else begin
            tick   = clk_500 && !m_prev;
            m_prev = clk_500;
            exp_fd = 1'b0;
            if (tick) begin
                if (m_idx == 7 && m_pv) begin
                    m_data = p_data; m_dpb = p_dpb; m_pv = 0; exp_fd = 1'b1;
                end
                m_idx   = (m_idx + 1) % 8;
                exp_an  = ~(8'd1 << m_idx);
                exp_seg = ref_seg(m_data, m_idx, blank_lz);
                exp_dp  = ~m_dpb[m_idx];
            end
            if (load) begin
                p_data = data_in; p_dpb = dp_in; m_pv = 1;
            end
        end
        #1;
        chk("an", 32'(an), 32'(exp_an));
        chk("seg", 32'(seg), 32'(exp_seg));
        chk("dp", 32'(dp), 32'(exp_dp));
        chk("frame_done", 32'(frame_done), 32'(exp_fd));
    endtask

    task automatic tick_rise();
        clk_500 = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic tick_fall();
        clk_500 = 1'b0;
        step();
    endtask

    task automatic do_load(logic [31:0] d, logic [7:0] p);
        data_in = d; dp_in = p; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; clk_500 = 1'b0; data_in = '0; dp_in = '0; load = 1'b0; blank_lz = 1'b0;

        // Reset, then idle with no tick
        step(); step();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) step();
        chk("rst_an", 32'(an), 32'hFF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(dp), 32'h1);
        chk("rst_fd", 32'(frame_done), 32'h0);

        // 12345678 scanned digit 0..7
        do_load(32'h12345678, 8'h00);
        tick_rise();
        chk("first_an", 32'(an), 32'hFE);
        chk("first_seg", 32'(seg), 32'(7'b0000000));
        chk("first_fd", 32'(frame_done), 32'h1);
        tick_fall();
        for (int k = 1; k < 8; k++) begin tick_rise(); tick_fall(); end
        chk("last_an", 32'(an), 32'h7F);
        chk("last_seg", 32'(seg), 32'(7'b1111001));

        // Leading-zero suppression with a decimal point on blanked digit 7
        blank_lz = 1'b1;
        do_load(32'h000000A0, 8'h80);
        for (int k = 0; k < 8; k++) begin
            tick_rise();
            if (k == 0) chk("lz_d0", 32'(seg), 32'(7'b1000000));
            if (k == 1) chk("lz_d1", 32'(seg), 32'(7'b0001000));
            if (k == 7) begin
                chk("lz_d7_seg", 32'(seg), 32'h7F);
                chk("lz_d7_dp", 32'(dp), 32'h0);
            end
            tick_fall();
        end
        blank_lz = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick_rise();
            if (k == 7) chk("nolz_d7", 32'(seg), 32'(7'b1000000));
            tick_fall();
        end

        // Mid-frame load does not disturb the current frame
        do_load(32'hFFFFFFFF, 8'h00);
        for (int k = 0; k < 4; k++) begin tick_rise(); tick_fall(); end
        do_load(32'hAAAAAAAA, 8'h00);
        for (int k = 4; k < 8; k++) begin
            tick_rise();
            chk("mid_old_F", 32'(seg), 32'(7'b0001110));
            tick_fall();
        end
        tick_rise();
        chk("mid_new_A", 32'(seg), 32'(7'b0001000));
        tick_fall();

        // Load in the exact wrap cycle with another value pending
        do_load(32'h22222222, 8'h00);
        for (int k = 1; k < 8; k++) begin tick_rise(); tick_fall(); end
        data_in = 32'h11111111; load = 1'b1;
        tick_rise();
        chk("wrap_old_2", 32'(seg), 32'(7'b0100100));
        chk("wrap_fd1", 32'(frame_done), 32'h1);
        tick_fall();
        for (int k = 1; k < 8; k++) begin tick_rise(); tick_fall(); end
        tick_rise();
        chk("wrap_new_1", 32'(seg), 32'(7'b1111001));
        chk("wrap_fd2", 32'(frame_done), 32'h1);
        tick_fall();

        // Reset on digit 5 with a load pending
        for (int k = 1; k < 6; k++) begin tick_rise(); tick_fall(); end
        chk("pre_rst_an", 32'(an), 32'hDF);
        do_load(32'h33333333, 8'hFF);
        rst = 1'b1;
        step();
        chk("mid_rst_an", 32'(an), 32'hFF);
        chk("mid_rst_seg", 32'(seg), 32'h7F);
        rst = 1'b0;
        step();
        tick_rise();
        chk("post_rst_an", 32'(an), 32'hFE);
        chk("post_rst_seg", 32'(seg), 32'(7'b1000000));
        chk("post_rst_dp", 32'(dp), 32'h1);
        tick_fall();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            clk_500  = 1'($urandom_range(0, 1));
            load     = ($urandom_range(0, 15) == 0);
            data_in  = $urandom >> (4 * $urandom_range(0, 8));
            dp_in    = 8'($urandom);
            if ($urandom_range(0, 63) == 0) blank_lz = ~blank_lz;
            rst      = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 1'b0; load = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
